// File: rtl/isram_axil_if.sv
// AXI-lite read-only fetch channel (AR + R) between the IFU and the instruction SRAM.
// Handshake: a beat transfers on a rising edge where valid && ready; valid is never gated by ready.
interface isram_axil_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output araddr, arvalid, rready,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  araddr, arvalid, rready,
    output arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/isram_axil.sv
// Instruction SRAM behind a single-outstanding AXI-lite read slave with configurable access latency
// and a backdoor load port used to place the program image.
module isram_axil #(
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int          DEPTH_LOG2 = 12,
  parameter int          LATENCY    = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  isram_axil_if.slave           axi,
  input  logic                  ld_we_i,
  input  logic [DEPTH_LOG2-1:0] ld_addr_i,
  input  logic [31:0]           ld_wdata_i,
  output logic [1:0]            dbg_state_o
);

  localparam logic [1:0] ST_RST  = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [32:0] MEM_BYTES = 33'd4 << DEPTH_LOG2;
  localparam logic [3:0]  CNT_INIT  = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  logic [1:0]  r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_rdata;
  logic [1:0]  r_rresp;
  logic [31:0] r_mem [2**DEPTH_LOG2];

  logic [31:0]           w_dec_addr;
  logic [31:0]           w_off;
  logic                  w_misalign;
  logic                  w_oor;
  logic                  w_accept;
  logic                  w_load;
  logic [DEPTH_LOG2-1:0] w_idx;

  // With zero latency the response is decoded straight from the bus address on the accept edge.
  assign w_accept   = (r_state == ST_IDLE) && axi.arvalid;
  assign w_load     = (w_accept && (LATENCY == 0)) || ((r_state == ST_WAIT) && (r_cnt == 4'd0));
  assign w_dec_addr = (r_state == ST_IDLE) ? axi.araddr : r_addr;
  assign w_off      = w_dec_addr - BASE_ADDR;
  assign w_misalign = |w_dec_addr[1:0];
  assign w_oor      = {1'b0, w_off} >= MEM_BYTES;
  assign w_idx      = w_off[DEPTH_LOG2+1:2];

  always_ff @(posedge clk_i) begin
    if (ld_we_i) begin
      r_mem[ld_addr_i] <= ld_wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ST_RST;
      r_cnt   <= 4'd0;
      r_addr  <= 32'd0;
      r_rdata <= 32'd0;
      r_rresp <= RESP_OKAY;
    end else begin
      // Array read samples pre-edge contents, so a same-edge backdoor write returns old data.
      if (w_load) begin
        if (w_misalign) begin
          r_rresp <= RESP_SLVERR;
          r_rdata <= 32'd0;
        end else if (w_oor) begin
          r_rresp <= RESP_DECERR;
          r_rdata <= 32'd0;
        end else begin
          r_rresp <= RESP_OKAY;
          r_rdata <= r_mem[w_idx];
        end
      end
      case (r_state)
        ST_RST:  r_state <= ST_IDLE;
        ST_IDLE: begin
          if (axi.arvalid) begin
            r_addr <= axi.araddr;
            if (LATENCY == 0) begin
              r_state <= ST_RESP;
            end else begin
              r_state <= ST_WAIT;
              r_cnt   <= CNT_INIT;
            end
          end
        end
        ST_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (axi.rready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_RST;
      endcase
    end
  end

  assign axi.arready = (r_state == ST_IDLE);
  assign axi.rvalid  = (r_state == ST_RESP);
  assign axi.rdata   = r_rdata;
  assign axi.rresp   = r_rresp;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_isram_axil.sv
// Bench for isram_axil: three instances (LATENCY 1, 0, 3) share clock, reset and the loader bus.
module tb_isram_axil;

  localparam logic [31:0] BASE   = 32'h8000_0000;
  localparam int          NWORDS = 4096;
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;
  localparam logic [1:0]  DECERR = 2'b11;

  int lat_of [3] = '{1, 0, 3};

  logic        clk;
  logic        rst_n;
  logic        ld_we;
  logic [11:0] ld_addr;
  logic [31:0] ld_wdata;

  logic [31:0] araddr  [3];
  logic        arvalid [3];
  logic        rready  [3];
  logic        arready [3];
  logic [31:0] rdata   [3];
  logic [1:0]  rresp   [3];
  logic        rvalid  [3];
  logic [1:0]  dbg_state [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
    isram_axil_if bus ();
    assign bus.araddr  = araddr[g];
    assign bus.arvalid = arvalid[g];
    assign bus.rready  = rready[g];
    assign arready[g]  = bus.arready;
    assign rdata[g]    = bus.rdata;
    assign rresp[g]    = bus.rresp;
    assign rvalid[g]   = bus.rvalid;
    isram_axil #(.BASE_ADDR(32'h8000_0000), .DEPTH_LOG2(12), .LATENCY(LAT)) u_dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .axi         (bus),
      .ld_we_i     (ld_we),
      .ld_addr_i   (ld_addr),
      .ld_wdata_i  (ld_wdata),
      .dbg_state_o (dbg_state[g])
    );
  end

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] ref_mem [NWORDS];
  int          loaded_q [$];
  logic [31:0] exp_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // reference: decode rules computed arithmetically from the address
  function automatic void model(input logic [31:0] addr, output logic [1:0] resp, output logic [31:0] data);
    logic [31:0] off;
    off = addr - BASE;
    if (addr % 4 != 0) begin
      resp = SLVERR; data = 32'd0;
    end else if (off >= 32'(NWORDS * 4)) begin
      resp = DECERR; data = 32'd0;
    end else begin
      resp = OKAY; data = ref_mem[off / 4];
    end
  endfunction

  // driver tasks
  task automatic ld(input int idx, input logic [31:0] val);
    @(negedge clk);
    ld_we = 1'b1; ld_addr = 12'(idx); ld_wdata = val;
    @(negedge clk);
    ld_we = 1'b0;
    ref_mem[idx] = val;
    loaded_q.push_back(idx);
  endtask

  task automatic fetch(input int d, input logic [31:0] addr, input int stall,
                       output logic [31:0] data, output logic [1:0] resp, output int lat, output bit ok);
    int w;
    ok = 1'b0; data = '0; resp = '0; lat = -1;
    @(negedge clk);
    araddr[d] = addr; arvalid[d] = 1'b1;
    w = 0;
    while (!arready[d] && w < 50) begin @(negedge clk); w++; end
    if (!arready[d]) begin
      check("ar_timeout", 64'd0, 64'd1);
      arvalid[d] = 1'b0;
      return;
    end
    @(negedge clk);
    arvalid[d] = 1'b0;
    lat = 0;
    while (!rvalid[d] && lat < 50) begin @(negedge clk); lat++; end
    if (!rvalid[d]) begin
      check("r_timeout", 64'd0, 64'd1);
      return;
    end
    data = rdata[d]; resp = rresp[d];
    check("resp_arready_low", 64'(arready[d]), 64'd0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check($sformatf("stall_rvalid[%0d]", i), 64'(rvalid[d]), 64'd1);
      check($sformatf("stall_rdata[%0d]", i), 64'(rdata[d]), 64'(data));
      check($sformatf("stall_rresp[%0d]", i), 64'(rresp[d]), 64'(resp));
      check($sformatf("stall_arready[%0d]", i), 64'(arready[d]), 64'd0);
    end
    rready[d] = 1'b1;
    @(negedge clk);
    rready[d] = 1'b0;
    check("release_rvalid", 64'(rvalid[d]), 64'd0);
    check("release_arready", 64'(arready[d]), 64'd1);
    ok = 1'b1;
  endtask

  task automatic fetch_check(input int d, input logic [31:0] addr, input int stall);
    logic [31:0] ed, gd;
    logic [1:0]  er, gr;
    int          lat;
    bit          ok;
    model(addr, er, ed);
    fetch(d, addr, stall, gd, gr, lat, ok);
    if (ok) begin
      check($sformatf("rdata d%0d @%h", d, addr), 64'(gd), 64'(ed));
      check($sformatf("rresp d%0d @%h", d, addr), 64'(gr), 64'(er));
      check($sformatf("latency d%0d @%h", d, addr), 64'(lat), 64'(lat_of[d]));
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    int          stall;
    logic [1:0]  resp;
    logic [31:0] data;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [31:0] gd, old;
    logic [1:0]  gr;
    int          lat, cyc, last_acc, n_acc, n_pop, w;
    bit          ok;
    logic [31:0] a;

    rst_n = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_wdata = '0;
    for (int i = 0; i < 3; i++) begin
      araddr[i] = '0; arvalid[i] = 1'b0; rready[i] = 1'b0;
    end
    for (int i = 0; i < NWORDS; i++) ref_mem[i] = '0;

    vecs[0] = '{addr: 32'h8000_0000, stall: 5, resp: OKAY,   data: 32'h0000_0413};
    vecs[1] = '{addr: 32'h8000_0002, stall: 0, resp: SLVERR, data: 32'h0000_0000};
    vecs[2] = '{addr: 32'h8000_4000, stall: 1, resp: DECERR, data: 32'h0000_0000};
    vecs[3] = '{addr: 32'h7FFF_FFFC, stall: 0, resp: DECERR, data: 32'h0000_0000};
    vecs[4] = '{addr: 32'h8000_3FFC, stall: 2, resp: OKAY,   data: 32'hCAFE_F00D};
    vecs[5] = '{addr: 32'h8000_0004, stall: 0, resp: OKAY,   data: 32'h0010_0093};

    // reset state, and loads that land while still in reset
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_arready d%0d", i), 64'(arready[i]), 64'd0);
      check($sformatf("rst_rvalid d%0d", i),  64'(rvalid[i]),  64'd0);
      check($sformatf("rst_rdata d%0d", i),   64'(rdata[i]),   64'd0);
      check($sformatf("rst_rresp d%0d", i),   64'(rresp[i]),   64'd0);
    end
    ld(0, 32'h0000_0413);
    ld(1, 32'h0010_0093);
    ld(4095, 32'hCAFE_F00D);
    @(negedge clk);
    #1 rst_n = 1'b1;
    #1 check("release_still_rst", 64'(arready[0]), 64'd0);
    @(negedge clk);
    for (int i = 0; i < 3; i++)
      check($sformatf("idle_arready d%0d", i), 64'(arready[i]), 64'd1);

    // table: first fetch, backpressure, error decode, top word
    for (int i = 0; i < 6; i++) begin
      fetch(0, vecs[i].addr, vecs[i].stall, gd, gr, lat, ok);
      if (ok) begin
        check($sformatf("vec%0d_rdata", i), 64'(gd), 64'(vecs[i].data));
        check($sformatf("vec%0d_rresp", i), 64'(gr), 64'(vecs[i].resp));
        check($sformatf("vec%0d_latency", i), 64'(lat), 64'd1);
      end
    end

    // back-to-back, LATENCY=0, arvalid/rready held high
    for (int i = 0; i < 8; i++) ld(i, $urandom);
    exp_q.delete();
    n_acc = 0; n_pop = 0; cyc = 0; last_acc = 0;
    @(negedge clk);
    araddr[1] = BASE; arvalid[1] = 1'b1; rready[1] = 1'b1;
    while (n_pop < 8 && cyc < 60) begin
      if (rvalid[1]) begin
        if (exp_q.size() == 0) check("b2b_unexpected_beat", 64'd1, 64'd0);
        else check($sformatf("b2b_rdata[%0d]", n_pop), 64'(rdata[1]), 64'(exp_q.pop_front()));
        check($sformatf("b2b_rresp[%0d]", n_pop), 64'(rresp[1]), 64'(OKAY));
        n_pop++;
      end
      if (arready[1] && arvalid[1]) begin
        exp_q.push_back(ref_mem[n_acc]);
        if (n_acc > 0) check($sformatf("b2b_interval[%0d]", n_acc), 64'(cyc - last_acc), 64'd2);
        last_acc = cyc;
        n_acc++;
      end else if (!arready[1]) begin
        if (n_acc < 8) araddr[1] = BASE + 32'(4 * n_acc);
        else arvalid[1] = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    arvalid[1] = 1'b0; rready[1] = 1'b0;
    check("b2b_beats", 64'(n_pop), 64'd8);

    // async reset pulsed while waiting (LATENCY=3)
    @(negedge clk);
    araddr[2] = BASE; arvalid[2] = 1'b1;
    check("wait_pre_arready", 64'(arready[2]), 64'd1);
    @(negedge clk);
    arvalid[2] = 1'b0;
    check("wait_arready", 64'(arready[2]), 64'd0);
    #1 rst_n = 1'b0;
    #1 check("wait_rst_rvalid", 64'(rvalid[2]), 64'd0);
    check("wait_rst_arready", 64'(arready[2]), 64'd0);
    #1 rst_n = 1'b1;
    #1 check("wait_post_release_arready", 64'(arready[2]), 64'd0);
    @(negedge clk);
    check("wait_idle_arready", 64'(arready[2]), 64'd1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("wait_no_stale_r[%0d]", i), 64'(rvalid[2]), 64'd0);
    end

    // async reset pulsed while a beat is presented (LATENCY=1)
    @(negedge clk);
    araddr[0] = BASE; arvalid[0] = 1'b1;
    @(negedge clk);
    arvalid[0] = 1'b0;
    w = 0;
    while (!rvalid[0] && w < 20) begin @(negedge clk); w++; end
    check("resp_rst_pre_rvalid", 64'(rvalid[0]), 64'd1);
    #1 rst_n = 1'b0;
    #1 check("resp_rst_rvalid", 64'(rvalid[0]), 64'd0);
    check("resp_rst_rdata", 64'(rdata[0]), 64'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("resp_rst_idle", 64'(arready[0]), 64'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("resp_no_stale_r[%0d]", i), 64'(rvalid[0]), 64'd0);
    end

    // backdoor write on the edge that enters RESP: old data returned, refetch sees new
    ld(1, 32'h0010_0093);
    old = ref_mem[1];
    @(negedge clk);
    araddr[0] = BASE + 32'd4; arvalid[0] = 1'b1;
    check("rbw_arready", 64'(arready[0]), 64'd1);
    @(negedge clk);
    arvalid[0] = 1'b0;
    ld_we = 1'b1; ld_addr = 12'd1; ld_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    ld_we = 1'b0;
    ref_mem[1] = 32'hDEAD_BEEF;
    check("rbw_rvalid", 64'(rvalid[0]), 64'd1);
    check("rbw_old_data", 64'(rdata[0]), 64'(old));
    rready[0] = 1'b1;
    @(negedge clk);
    rready[0] = 1'b0;
    fetch_check(0, BASE + 32'd4, 0);

    // randomized fetches against the reference model
    for (int i = 0; i < 60; i++) begin
      int d, kind;
      d = $urandom_range(0, 2);
      if ($urandom_range(0, 3) == 0) ld($urandom_range(0, NWORDS - 1), $urandom);
      kind = $urandom_range(0, 9);
      case (kind)
        6: a = BASE + 32'(4 * $urandom_range(0, NWORDS - 1)) + 32'($urandom_range(1, 3));
        7: a = BASE + 32'(4 * NWORDS) + 32'(4 * $urandom_range(0, 1000));
        8: a = BASE - 32'(4 * $urandom_range(1, 1000));
        9: a = $urandom;
        default: a = BASE + 32'(4 * loaded_q[$urandom_range(0, loaded_q.size() - 1)]);
      endcase
      if (kind == 9 && (a % 4 == 0) && (a - BASE) < 32'(4 * NWORDS)) a = a | 32'd1;
      fetch_check(d, a, $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
